merge_tree_scheduler: RTL

//  Collects the M per-field RIDS of one packet from the field lookup engines (valid/ready, any

---
 rtl/merge_tree_scheduler_pkg.sv | 19 +
 rtl/merge_tree_scheduler_fifo.sv | 64 ++++++
 rtl/merge_tree_scheduler.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/merge_tree_scheduler_pkg.sv
// Shared types and default sizing for the merge tree scheduler and its output FIFO.
package merge_tree_pkg;

   localparam int DEF_M         = 8;
   localparam int DEF_LOG_M     = 3;
   localparam int DEF_RID_WIDTH = 4;
   localparam int DEF_NUM_RID   = 8;
   localparam int DEF_TREE_LAT  = 12;
   localparam int DEF_PKT_ID_W  = 8;
   localparam int DEF_OUT_DEPTH = 4;

   localparam int RIDS_W = DEF_RID_WIDTH * DEF_NUM_RID;

   typedef enum logic {
      ST_COLLECT     = 1'b0,
      ST_WAIT_CREDIT = 1'b1
   } sched_state_t;

endpackage

// File: rtl/merge_tree_scheduler_fifo.sv
// Synchronous first-word-fall-through FIFO holding {pkt_id, merged RIDS} results.
module rids_out_fifo
   import merge_tree_pkg::*;
#(
   parameter int WIDTH = DEF_PKT_ID_W + RIDS_W,
   parameter int DEPTH = DEF_OUT_DEPTH,
   parameter int CNT_W = $clog2(DEPTH + 1)
)(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_push_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_head,
   output logic             o_empty,
   output logic             o_full,
   output logic [CNT_W-1:0] o_count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_do_push;
   logic             w_do_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign o_empty   = (r_count == '0);
   assign o_full    = (r_count == CNT_W'(DEPTH));
   assign o_count   = r_count;
   assign o_head    = r_mem[r_rd_ptr];
   assign w_do_pop  = i_pop && !o_empty;
   // When full, a same-cycle pop frees the head slot that the push then reuses.
   assign w_do_push = i_push && (!o_full || w_do_pop);

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
         if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
      !(i_push && o_full && !i_pop));

endmodule

// File: rtl/merge_tree_scheduler.sv
// Assembles per-field RIDS into one vector, launches it into the fixed-latency merge
// tree under a credit check, and queues tree results with their packet IDs.
module merge_tree_scheduler
   import merge_tree_pkg::*;
#(
   parameter int M         = DEF_M,
   parameter int LOG_M     = DEF_LOG_M,
   parameter int RID_WIDTH = DEF_RID_WIDTH,
   parameter int NUM_RID   = DEF_NUM_RID,
   parameter int TREE_LAT  = DEF_TREE_LAT,
   parameter int PKT_ID_W  = DEF_PKT_ID_W,
   parameter int OUT_DEPTH = DEF_OUT_DEPTH
)(
   input  logic                               clk,
   input  logic                               reset_n,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic [LOG_M-1:0]                   in_field,
   input  logic [PKT_ID_W-1:0]                in_pkt_id,
   input  logic [RID_WIDTH*NUM_RID-1:0]       in_rids,
   output logic [RID_WIDTH*NUM_RID*M-1:0]     tree_in,
   input  logic [RID_WIDTH*NUM_RID-1:0]       tree_out,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [PKT_ID_W-1:0]                out_pkt_id,
   output logic [RID_WIDTH*NUM_RID-1:0]       out_rids,
   output logic                               err,
   output logic                               busy
);

   localparam int LP_RIDS_W = RID_WIDTH * NUM_RID;
   localparam int LP_CNT_W  = $clog2(OUT_DEPTH + 1);
   localparam logic [LP_CNT_W:0] LP_DEPTH = (LP_CNT_W + 1)'(OUT_DEPTH);

   sched_state_t          r_state;
   logic [M-1:0]          r_mask;
   logic [PKT_ID_W-1:0]   r_cur_id;
   logic                  r_in_ready;
   logic                  r_err;
   logic [TREE_LAT-1:0]   r_pipe_vld;
   logic [PKT_ID_W-1:0]   r_pipe_id [TREE_LAT];
   logic [LP_CNT_W-1:0]   r_inflight;

   logic [M-1:0]          w_field_hit;
   logic [M-1:0]          w_mask_set;
   logic                  w_accept;
   logic                  w_id_ok;
   logic                  w_slot_wr;
   logic                  w_launch;
   logic                  w_credit_ok;
   logic [LP_CNT_W:0]     w_credit_sum;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_fifo_empty;
   logic                  w_fifo_full;
   logic [LP_CNT_W-1:0]   w_fifo_count;
   logic [PKT_ID_W+LP_RIDS_W-1:0] w_fifo_head;

   assign w_accept   = in_valid && r_in_ready;
   assign w_id_ok    = (r_mask == '0) || (in_pkt_id == r_cur_id);
   assign w_slot_wr  = w_accept && w_id_ok;
   assign w_mask_set = r_mask | w_field_hit;

   // Slot buffer drives the tree directly; it only changes while in_ready is high.
   for (genvar gi = 0; gi < M; gi++) begin : g_slot
      logic [LP_RIDS_W-1:0] r_data;
      assign w_field_hit[gi] = (in_field == LOG_M'(gi));
      always_ff @(posedge clk) begin
         if (!reset_n)                          r_data <= '0;
         else if (w_slot_wr && w_field_hit[gi]) r_data <= in_rids;
      end
      assign tree_in[gi*LP_RIDS_W +: LP_RIDS_W] = r_data;
   end

   // Packets in the tree plus packets buffered must never exceed the FIFO depth.
   assign w_credit_sum = {1'b0, r_inflight} + {1'b0, w_fifo_count};
   assign w_credit_ok  = (w_credit_sum < LP_DEPTH);
   assign w_launch     = (r_state == ST_WAIT_CREDIT) && w_credit_ok;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state    <= ST_COLLECT;
         r_mask     <= '0;
         r_cur_id   <= '0;
         r_in_ready <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_err <= 1'b0;
         case (r_state)
            ST_COLLECT: begin
               r_in_ready <= 1'b1;
               if (w_accept) begin
                  if (r_mask == '0) r_cur_id <= in_pkt_id;
                  if (!w_id_ok) begin
                     r_err <= 1'b1;
                  end else begin
                     if ((r_mask & w_field_hit) != '0) r_err <= 1'b1;
                     r_mask <= w_mask_set;
                     if (&w_mask_set) begin
                        r_state    <= ST_WAIT_CREDIT;
                        r_in_ready <= 1'b0;
                     end
                  end
               end
            end
            ST_WAIT_CREDIT: begin
               if (w_launch) begin
                  r_state    <= ST_COLLECT;
                  r_mask     <= '0;
                  r_in_ready <= 1'b1;
               end
            end
            default: begin
               r_state    <= ST_COLLECT;
               r_in_ready <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_pipe_vld <= '0;
         for (int i = 0; i < TREE_LAT; i++) r_pipe_id[i] <= '0;
      end else begin
         r_pipe_vld[0] <= w_launch;
         r_pipe_id[0]  <= r_cur_id;
         for (int i = 1; i < TREE_LAT; i++) begin
            r_pipe_vld[i] <= r_pipe_vld[i-1];
            r_pipe_id[i]  <= r_pipe_id[i-1];
         end
      end
   end

   assign w_push = r_pipe_vld[TREE_LAT-1];

   always_ff @(posedge clk) begin
      if (!reset_n)                  r_inflight <= '0;
      else if (w_launch && !w_push)  r_inflight <= r_inflight + 1'b1;
      else if (!w_launch && w_push)  r_inflight <= r_inflight - 1'b1;
   end

   assign w_pop = out_valid && out_ready;

   rids_out_fifo #(
      .WIDTH (PKT_ID_W + LP_RIDS_W),
      .DEPTH (OUT_DEPTH),
      .CNT_W (LP_CNT_W)
   ) u_out_fifo (
      .clk         (clk),
      .reset_n     (reset_n),
      .i_push      (w_push),
      .i_push_data ({r_pipe_id[TREE_LAT-1], tree_out}),
      .i_pop       (w_pop),
      .o_head      (w_fifo_head),
      .o_empty     (w_fifo_empty),
      .o_full      (w_fifo_full),
      .o_count     (w_fifo_count)
   );

   assign in_ready   = r_in_ready;
   assign err        = r_err;
   assign out_valid  = !w_fifo_empty;
   assign out_pkt_id = w_fifo_head[LP_RIDS_W +: PKT_ID_W];
   assign out_rids   = w_fifo_head[LP_RIDS_W-1:0];
   assign busy       = (r_mask != '0) || (r_inflight != '0) || !w_fifo_empty
                       || (w_fifo_full && 1'b0);

endmodule
